hex_rate_counter: RTL and testbench

Rate-divided 4-bit hex digit counter that drives the 7-segment hex decoder stage on the board. It divides the board clock down to a selectable rate and steps a digit up or down. The 4-bit `digit` output connects directly to the decoder's 4-bit input, and the decoder turns it into active-low segments on a HEX display. The block also provides load, pause, and one-cycle tick/wrap strobes for downstream status LEDs.

---
 rtl/hex_rate_counter.sv | 118 +++++++++++
 tb/tb_hex_rate_counter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/hex_rate_counter.sv
// Rate-divided hex digit counter with load, pause and tick/wrap strobes.
// Define HEX_COUNTER_BCD_EN to restrict the digit to the decimal range 0-9.
module hex_rate_counter #(
  parameter int unsigned CLK_HZ    = 50000000,
  parameter int unsigned DIV_WIDTH = 28
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] speed,
  input  logic       up_down,
  input  logic       load,
  input  logic [3:0] load_value,
  output logic [3:0] digit,
  output logic       tick,
  output logic       wrap
);

`ifdef HEX_COUNTER_BCD_EN
  localparam logic [3:0] DIG_MAX = 4'd9;
`else
  localparam logic [3:0] DIG_MAX = 4'hF;
`endif

  localparam logic [DIV_WIDTH-1:0] P1_M1 = DIV_WIDTH'(CLK_HZ - 1);
  localparam logic [DIV_WIDTH-1:0] P2_M1 = DIV_WIDTH'(2 * CLK_HZ - 1);
  localparam logic [DIV_WIDTH-1:0] P4_M1 = DIV_WIDTH'(4 * CLK_HZ - 1);

  typedef enum logic {PAUSE = 1'b0, RUN = 1'b1} state_e;

  state_e               state_q;
  logic [DIV_WIDTH-1:0] div_q;
  logic [1:0]           speed_q;
  logic [3:0]           digit_q;
  logic                 tick_q;
  logic                 wrap_q;

  logic [3:0]           step_digit_c;
  logic                 step_wrap_c;
  logic [3:0]           load_digit_c;
  logic                 unused_run;

  // Divider reload value for a given rate select.
  function automatic logic [DIV_WIDTH-1:0] period_m1(input logic [1:0] s);
    case (s)
      2'b00:   period_m1 = '0;
      2'b01:   period_m1 = P1_M1;
      2'b10:   period_m1 = P2_M1;
      default: period_m1 = P4_M1;
    endcase
  endfunction

  // Next digit and wrap flag for a step, plus the loadable value.
  always_comb begin
    step_digit_c = digit_q;
    step_wrap_c  = 1'b0;
    load_digit_c = load_value;
`ifdef HEX_COUNTER_BCD_EN
    if (load_value > DIG_MAX) load_digit_c = DIG_MAX;
    if (up_down) begin
      step_wrap_c  = (digit_q == DIG_MAX);
      step_digit_c = (digit_q >= DIG_MAX) ? 4'd0 : 4'(digit_q + 4'd1);
    end else begin
      step_wrap_c = (digit_q == 4'd0);
      if (digit_q == 4'd0 || digit_q > DIG_MAX) step_digit_c = DIG_MAX;
      else                                      step_digit_c = 4'(digit_q - 4'd1);
    end
`else
    if (up_down) begin
      step_wrap_c  = (digit_q == DIG_MAX);
      step_digit_c = 4'(digit_q + 4'd1);
    end else begin
      step_wrap_c  = (digit_q == 4'd0);
      step_digit_c = 4'(digit_q - 4'd1);
    end
`endif
  end

  // Priority: reset > load > speed change > step.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= PAUSE;
      div_q   <= period_m1(speed);
      speed_q <= speed;
      digit_q <= 4'd0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= enable ? RUN : PAUSE;
      speed_q <= speed;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
      if (load) begin
        digit_q <= load_digit_c;
        div_q   <= period_m1(speed);
      end else if (speed != speed_q) begin
        div_q <= period_m1(speed);
      end else if (enable) begin
        if (div_q == '0) begin
          digit_q <= step_digit_c;
          tick_q  <= 1'b1;
          wrap_q  <= step_wrap_c;
          div_q   <= period_m1(speed_q);
        end else begin
          div_q <= DIV_WIDTH'(div_q - 1'b1);
        end
      end
    end
  end

  // Run/pause state only mirrors enable; kept for debug visibility.
  assign unused_run = (state_q == RUN);

  assign digit = digit_q;
  assign tick  = tick_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_hex_rate_counter.sv
// Scoreboard bench for hex_rate_counter: reference model pushes expected outputs, monitor compares.
module tb_hex_rate_counter;

  localparam int unsigned CLK_HZ    = 4;
  localparam int unsigned DIV_WIDTH = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] speed = 2'b00;
  logic       up_down = 1'b1;
  logic       load = 1'b0;
  logic [3:0] load_value = 4'd0;
  logic [3:0] digit;
  logic       tick;
  logic       wrap;

  hex_rate_counter #(.CLK_HZ(CLK_HZ), .DIV_WIDTH(DIV_WIDTH)) dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .enable    (enable),
    .speed     (speed),
    .up_down   (up_down),
    .load      (load),
    .load_value(load_value),
    .digit     (digit),
    .tick      (tick),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    int unsigned dig;
    bit          tck;
    bit          wrp;
  } exp_t;

  exp_t exp_q[$];
  int unsigned passed = 0;
  int unsigned total  = 0;
  int unsigned cyc    = 0;
  bit          done   = 1'b0;

`ifdef HEX_COUNTER_BCD_EN
  localparam int unsigned NDIG = 10;
`else
  localparam int unsigned NDIG = 16;
`endif

  // Reference model: counts enabled cycles since the rate period last restarted.
  bit          m_valid = 1'b0;
  int unsigned m_digit, m_elapsed, m_speed;
  bit          m_tick, m_wrap;

  function automatic int unsigned period(input int unsigned s);
    case (s)
      0:       return 1;
      1:       return CLK_HZ;
      2:       return 2 * CLK_HZ;
      default: return 4 * CLK_HZ;
    endcase
  endfunction

  task automatic model_edge();
    m_tick = 1'b0;
    m_wrap = 1'b0;
    if (reset) begin
      m_valid = 1'b1; m_digit = 0; m_elapsed = 0; m_speed = speed;
    end else if (m_valid) begin
      if (load) begin
        m_digit   = (load_value >= NDIG) ? NDIG - 1 : load_value;
        m_elapsed = 0;
      end else if (speed != m_speed) begin
        m_elapsed = 0;
      end else if (enable) begin
        if (m_elapsed + 1 == period(m_speed)) begin
          m_tick = 1'b1;
          if (up_down) begin
            m_wrap  = (m_digit == NDIG - 1);
            m_digit = (m_digit >= NDIG - 1) ? 0 : m_digit + 1;
          end else begin
            m_wrap  = (m_digit == 0);
            m_digit = (m_digit == 0 || m_digit >= NDIG) ? NDIG - 1 : m_digit - 1;
          end
          m_elapsed = 0;
        end else begin
          m_elapsed++;
        end
      end
      m_speed = speed;
    end
  endtask

  // Apply inputs for one edge, advance the model, queue the expectation.
  task automatic drive(input bit r, input bit e, input logic [1:0] s, input bit ud,
                       input bit ld, input logic [3:0] lv);
    exp_t x;
    reset = r; enable = e; speed = s; up_down = ud; load = ld; load_value = lv;
    @(posedge clk);
    cyc++;
    model_edge();
    if (m_valid) begin
      x.cyc = cyc; x.dig = m_digit; x.tck = m_tick; x.wrp = m_wrap;
      exp_q.push_back(x);
    end
    #1;
  endtask

  task automatic run(input int n, input bit e, input logic [1:0] s, input bit ud);
    for (int i = 0; i < n; i++) drive(1'b0, e, s, ud, 1'b0, 4'd0);
  endtask

  // Monitor: outputs are valid every cycle after reset, so compare on each falling edge.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        x = exp_q.pop_front();
        total++;
        if (digit == 4'(x.dig) && tick == x.tck && wrap == x.wrp) passed++;
        else $display("FAIL out_cyc%0d: got digit=%h tick=%b wrap=%b, expected digit=%h tick=%b wrap=%b",
                      x.cyc, digit, tick, wrap, 4'(x.dig), x.tck, x.wrp);
      end
    end
  end

  initial begin
    int guard;
    @(negedge clk);
    drive(1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 4'd0);
    drive(1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 4'd0);
    run(12, 1'b1, 2'b01, 1'b1);                        // 1 Hz up: tick every 4 cycles
    drive(1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 4'hE);        // load E and switch to full rate
    run(4, 1'b1, 2'b00, 1'b1);                         // F, 0 (wrap), 1, 2
    drive(1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 4'h0);
    run(3, 1'b1, 2'b00, 1'b0);                         // 0 -> F wrap going down
    drive(1'b0, 1'b1, 2'b11, 1'b1, 1'b0, 4'd0);        // speed change restarts divider
    run(5, 1'b1, 2'b11, 1'b1);
    run(20, 1'b0, 2'b11, 1'b1);                        // pause holds everything
    run(14, 1'b1, 2'b11, 1'b1);
    drive(1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 4'd0);
    guard = 0;
    while (m_elapsed != period(1) - 1 && guard < 8) begin
      run(1, 1'b1, 2'b01, 1'b1);
      guard++;
    end
    drive(1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 4'd7);        // load collides with due step
    run(8, 1'b1, 2'b01, 1'b1);
    drive(1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 4'hA);
    run(2, 1'b1, 2'b01, 1'b1);
    drive(1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 4'd0);        // reset mid-count
    run(6, 1'b1, 2'b01, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      automatic bit          r  = ($urandom_range(0, 199) == 0);
      automatic bit          e  = ($urandom_range(0, 9) < 8);
      automatic logic [1:0]  s  = ($urandom_range(0, 29) == 0) ? 2'($urandom) : speed;
      automatic bit          ud = ($urandom_range(0, 19) == 0) ? ~up_down : up_down;
      automatic bit          ld = ($urandom_range(0, 24) == 0);
      drive(r, e, s, ud, ld, 4'($urandom));
    end
    reset = 1'b0; load = 1'b0; enable = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no completion, expected finish before limit");
    $fatal(1, "timeout");
  end

endmodule
